// File: rtl/nco_phase_acc_if.sv
// Sample-side bundle of the NCO phase generator: control strobes in,
// phase word out toward the sin/cos table.
interface nco_phase_acc_if #(
    parameter int ACC_W = 32,
    parameter int PH_W  = 12
);
    logic             iv;
    logic             ifcw_v;
    logic [ACC_W-1:0] ifcw;
    logic             ipoff_v;
    logic [PH_W-1:0]  ipoff;
    logic             isync;
    logic             ov;
    logic [PH_W-1:0]  ophase;
    logic             owrap;

    modport master (
        output iv, ifcw_v, ifcw, ipoff_v, ipoff, isync,
        input  ov, ophase, owrap
    );

    modport slave (
        input  iv, ifcw_v, ifcw, ipoff_v, ipoff, isync,
        output ov, ophase, owrap
    );
endinterface

// File: rtl/nco_phase_acc.sv
// NCO phase accumulator: FCW shadow/active hand-over, phase offset, optional
// LFSR sub-LSB dither, two-stage registered pipeline to the phase output.
module nco_phase_acc #(
    parameter int          ACC_W     = 32,
    parameter int          PH_W      = 12,
    parameter bit          DITHER_EN = 1'b1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic          iclk,
    input  logic          ireset,
    nco_phase_acc_if.slave bus
);
    localparam int SH  = ACC_W - PH_W;
    localparam int DSH = ACC_W - PH_W - 16;

    logic [ACC_W-1:0] acc_q, fcw_act_q, fcw_shd_q, ph1_q;
    logic             pend_q, v1_q, w1_q;
    logic [PH_W-1:0]  poff_q;
    logic [15:0]      lfsr_q;
    logic             ov_q, owrap_q;
    logic [PH_W-1:0]  ophase_q;

    logic             hand;
    logic [ACC_W-1:0] fcw_eff, base, poff_ext, dith, ph1_d, acc_d;
    logic             w1_d;
    logic [PH_W-1:0]  ophase_d;
    logic [15:0]      lfsr_d;

    // Registered pend only: a load in this same cycle waits for the next strobe.
    assign hand     = pend_q & (bus.iv | bus.isync);
    assign fcw_eff  = hand ? fcw_shd_q : fcw_act_q;
    assign base     = bus.isync ? '0 : acc_q;
    assign poff_ext = {poff_q, {SH{1'b0}}};
    assign ph1_d    = base + poff_ext;
    assign {w1_d, acc_d} = {1'b0, base} + {1'b0, fcw_eff};

    assign dith     = DITHER_EN ? ({{(ACC_W-16){1'b0}}, lfsr_q} << DSH) : '0;
    assign ophase_d = PH_W'((ph1_q + dith) >> SH);
    assign lfsr_d   = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            acc_q     <= '0;
            fcw_act_q <= '0;
            fcw_shd_q <= '0;
            pend_q    <= 1'b0;
            poff_q    <= '0;
            lfsr_q    <= LFSR_SEED;
            v1_q      <= 1'b0;
            ph1_q     <= '0;
            w1_q      <= 1'b0;
            ov_q      <= 1'b0;
            ophase_q  <= '0;
            owrap_q   <= 1'b0;
        end else begin
            if (bus.ifcw_v)  fcw_shd_q <= bus.ifcw;
            if (hand)        fcw_act_q <= fcw_shd_q;
            if (bus.ifcw_v)  pend_q    <= 1'b1;
            else if (hand)   pend_q    <= 1'b0;
            if (bus.ipoff_v) poff_q    <= bus.ipoff;

            v1_q <= bus.iv;
            if (bus.iv) begin
                ph1_q <= ph1_d;
                acc_q <= acc_d;
                w1_q  <= w1_d;
            end else begin
                // Clear the carry so owrap never lingers outside a valid sample.
                w1_q <= 1'b0;
                if (bus.isync) acc_q <= '0;
            end

            ov_q    <= v1_q;
            owrap_q <= w1_q;
            if (v1_q) ophase_q <= ophase_d;

            if (bus.isync)  lfsr_q <= LFSR_SEED;
            else if (v1_q)  lfsr_q <= lfsr_d;
        end
    end

    assign bus.ov     = ov_q;
    assign bus.ophase = ophase_q;
    assign bus.owrap  = owrap_q;
endmodule

// File: tb/tb_nco_phase_acc.sv
// Directed bench for nco_phase_acc: vector table plus hand sequences for
// wrap, reset mid-stream and dither behaviour.
module tb_nco_phase_acc;
    localparam int ACC_W = 32;
    localparam int PH_W  = 12;

    logic iclk = 1'b0;
    logic ireset;
    always #5 iclk = ~iclk;

    nco_phase_acc_if #(.ACC_W(ACC_W), .PH_W(PH_W)) b0 ();
    nco_phase_acc_if #(.ACC_W(ACC_W), .PH_W(PH_W)) b1 ();

    nco_phase_acc #(.ACC_W(ACC_W), .PH_W(PH_W), .DITHER_EN(1'b0), .LFSR_SEED(16'hACE1)) dut (
        .iclk(iclk), .ireset(ireset), .bus(b0.slave)
    );
    nco_phase_acc #(.ACC_W(ACC_W), .PH_W(PH_W), .DITHER_EN(1'b1), .LFSR_SEED(16'hACE1)) dut_d (
        .iclk(iclk), .ireset(ireset), .bus(b1.slave)
    );

    typedef struct packed {
        logic        iv;
        logic        fv;
        logic [31:0] fcw;
        logic        pv;
        logic [11:0] po;
        logic        sy;
        logic        eov;
        logic [11:0] eph;
        logic        ew;
    } vec_t;

    vec_t tbl [31];
    int n_chk  = 0;
    int n_fail = 0;
    logic [11:0] dseq [2][41];
    logic any_diff;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic fv, input logic [31:0] fcw,
                         input logic pv, input logic [11:0] po, input logic sy);
        b0.iv = iv; b0.ifcw_v = fv; b0.ifcw = fcw; b0.ipoff_v = pv; b0.ipoff = po; b0.isync = sy;
        b1.iv = iv; b1.ifcw_v = fv; b1.ifcw = fcw; b1.ipoff_v = pv; b1.ipoff = po; b1.isync = sy;
    endtask

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    function automatic vec_t mk(input logic iv, input logic fv, input logic [31:0] fcw,
                                input logic pv, input logic [11:0] po, input logic sy,
                                input logic eov, input logic [11:0] eph);
        vec_t v;
        v.iv = iv; v.fv = fv; v.fcw = fcw; v.pv = pv; v.po = po; v.sy = sy;
        v.eov = eov; v.eph = eph; v.ew = 1'b0;
        return v;
    endfunction

    initial begin
        // Each row: inputs for one cycle, outputs expected just after that edge.
        tbl[0]  = mk(0, 1, 32'h0100_0000, 0, 12'h000, 0, 0, 12'h000);
        tbl[1]  = mk(1, 0, 32'h0,         0, 12'h000, 0, 0, 12'h000);
        tbl[2]  = mk(1, 0, 32'h0,         0, 12'h000, 0, 1, 12'h000);
        tbl[3]  = mk(1, 0, 32'h0,         0, 12'h000, 0, 1, 12'h010);
        tbl[4]  = mk(1, 0, 32'h0,         0, 12'h000, 0, 1, 12'h020);
        tbl[5]  = mk(1, 1, 32'h0200_0000, 0, 12'h000, 0, 1, 12'h030);
        tbl[6]  = mk(1, 0, 32'h0,         0, 12'h000, 0, 1, 12'h040);
        tbl[7]  = mk(1, 0, 32'h0,         0, 12'h000, 0, 1, 12'h050);
        tbl[8]  = mk(1, 0, 32'h0,         0, 12'h000, 0, 1, 12'h070);
        tbl[9]  = mk(0, 1, 32'h0100_0000, 0, 12'h000, 0, 1, 12'h090);
        tbl[10] = mk(0, 0, 32'h0,         0, 12'h000, 0, 0, 12'h090);
        tbl[11] = mk(1, 0, 32'h0,         1, 12'h800, 0, 0, 12'h090);
        tbl[12] = mk(1, 0, 32'h0,         0, 12'h000, 1, 1, 12'h0B0);
        tbl[13] = mk(1, 0, 32'h0,         0, 12'h000, 0, 1, 12'h800);
        tbl[14] = mk(1, 0, 32'h0,         0, 12'h000, 0, 1, 12'h810);
        tbl[15] = mk(0, 0, 32'h0,         0, 12'h000, 0, 1, 12'h820);
        tbl[16] = mk(0, 0, 32'h0,         1, 12'h000, 1, 0, 12'h820);
        tbl[17] = mk(1, 0, 32'h0,         0, 12'h000, 0, 0, 12'h820);
        tbl[18] = mk(0, 0, 32'h0,         0, 12'h000, 0, 1, 12'h000);
        tbl[19] = mk(0, 0, 32'h0,         0, 12'h000, 0, 0, 12'h000);
        tbl[20] = mk(1, 0, 32'h0,         0, 12'h000, 0, 0, 12'h000);
        tbl[21] = mk(0, 0, 32'h0,         0, 12'h000, 0, 1, 12'h010);
        tbl[22] = mk(1, 0, 32'h0,         0, 12'h000, 0, 0, 12'h010);
        tbl[23] = mk(0, 0, 32'h0,         0, 12'h000, 0, 1, 12'h020);
        tbl[24] = mk(0, 0, 32'h0,         0, 12'h000, 0, 0, 12'h020);
        tbl[25] = mk(0, 1, 32'h0010_0000, 0, 12'h000, 1, 0, 12'h020);
        tbl[26] = mk(1, 0, 32'h0,         0, 12'h000, 0, 0, 12'h020);
        tbl[27] = mk(1, 0, 32'h0,         0, 12'h000, 0, 1, 12'h000);
        tbl[28] = mk(1, 0, 32'h0,         0, 12'h000, 0, 1, 12'h001);
        tbl[29] = mk(0, 0, 32'h0,         0, 12'h000, 0, 1, 12'h002);
        tbl[30] = mk(0, 0, 32'h0,         0, 12'h000, 0, 0, 12'h002);

        ireset = 1'b1;
        drive(0, 0, 32'h0, 0, 12'h0, 0);
        #12;
        chk("rst_ov",     b0.ov,     0);
        chk("rst_phase",  b0.ophase, 0);
        chk("rst_wrap",   b0.owrap,  0);
        chk("rst_ov_d",   b1.ov,     0);
        ireset = 1'b0;

        for (int i = 0; i < 31; i++) begin
            drive(tbl[i].iv, tbl[i].fv, tbl[i].fcw, tbl[i].pv, tbl[i].po, tbl[i].sy);
            tick();
            chk($sformatf("vec%0d_ov", i),    b0.ov,     tbl[i].eov);
            chk($sformatf("vec%0d_phase", i), b0.ophase, tbl[i].eph);
            chk($sformatf("vec%0d_wrap", i),  b0.owrap,  tbl[i].ew);
        end

        // Reset with samples in flight and a pending FCW that must be lost.
        drive(0, 1, 32'h1000_0000, 0, 12'h0, 0); tick();
        drive(1, 0, 32'h0, 0, 12'h0, 0);         tick();
        tick();
        chk("pre_rst_ph_a", b0.ophase, 12'h003);
        drive(1, 1, 32'h2000_0000, 0, 12'h0, 0); tick();
        chk("pre_rst_ov",   b0.ov,     1);
        chk("pre_rst_ph_b", b0.ophase, 12'h103);
        drive(1, 0, 32'h0, 0, 12'h0, 0);
        #2 ireset = 1'b1;
        #1;
        chk("mid_rst_ov",    b0.ov,     0);
        chk("mid_rst_phase", b0.ophase, 0);
        chk("mid_rst_wrap",  b0.owrap,  0);
        tick();
        #2 ireset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("post_rst%0d_ov", k),    b0.ov,     (k >= 1) ? 1 : 0);
            chk($sformatf("post_rst%0d_phase", k), b0.ophase, 0);
            chk($sformatf("post_rst%0d_wrap", k),  b0.owrap,  0);
        end

        // Full wrap with FCW 0x0100_0000: 256 samples per revolution.
        drive(0, 1, 32'h0100_0000, 0, 12'h0, 0); tick();
        for (int k = 0; k < 262; k++) begin
            drive(1, 0, 32'h0, 0, 12'h0, 0);
            tick();
            if (k == 0) begin
                chk("wrap_first_ov", b0.ov, 0);
            end else begin
                chk($sformatf("wrap%0d_ov", k - 1),    b0.ov,     1);
                chk($sformatf("wrap%0d_phase", k - 1), b0.ophase, ((k - 1) * 16) & 12'hFFF);
                chk($sformatf("wrap%0d_wrap", k - 1),  b0.owrap,  ((k - 1) % 256 == 255) ? 1 : 0);
            end
        end
        drive(0, 0, 32'h0, 0, 12'h0, 0); tick(); tick();

        // Dither: compare against undithered n>>1, then resync and expect a repeat.
        ireset = 1'b1; #2; ireset = 1'b0;
        drive(0, 1, 32'h0008_0000, 0, 12'h0, 0); tick();
        any_diff = 1'b0;
        for (int p = 0; p < 2; p++) begin
            drive(1, 0, 32'h0, 0, 12'h0, 1); tick();
            for (int k = 0; k < 41; k++) begin
                logic [11:0] u, u1, d;
                drive(1, 0, 32'h0, 0, 12'h0, 0);
                tick();
                u  = 12'(k >> 1);
                u1 = u + 12'd1;
                d  = b1.ophase;
                dseq[p][k] = d;
                if (d != u) any_diff = 1'b1;
                chk($sformatf("dith_p%0d_%0d_ov", p, k),   b1.ov,     1);
                chk($sformatf("plain_p%0d_%0d_ph", p, k),  b0.ophase, u);
                chk($sformatf("dith_p%0d_%0d_rng", p, k),  (d == u || d == u1) ? 1 : 0, 1);
            end
            drive(0, 0, 32'h0, 0, 12'h0, 0); tick(); tick();
        end
        chk("dith_differs", any_diff, 1);
        for (int k = 0; k < 41; k++)
            chk($sformatf("dith_repeat%0d", k), dseq[1][k], dseq[0][k]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/nco_phase_acc.md
# nco_phase_acc

Numerically controlled oscillator phase generator that produces the 12-bit phase word consumed by the sin/cos lookup table. It keeps a wide phase accumulator that advances by a programmable frequency control word (FCW) on every valid input strobe. It adds a programmable phase offset and optional LFSR sub-LSB dither, then truncates to the table's phase width. Output valid/phase drive the table's `iv`/`iphase` directly.

## Interface
- `ACC_W`, 32, accumulator / FCW width
- `PH_W`, 12, output phase width; `ACC_W - PH_W >= 16` required
- `DITHER_EN`, 1, 1 = add LFSR dither below phase LSB, 0 = plain truncation
- `LFSR_SEED`, 16'hACE1, LFSR reset/sync value, must be nonzero

- `iclk`  in  1  clock
- `ireset`  in  1  reset, asynchronous, active-high
- `iv`  in  1  sample strobe; one phase output per strobe
- `ifcw_v`  in  1  load strobe for `ifcw`
- `ifcw`  in  ACC_W  new frequency control word, unsigned
- `ipoff_v`  in  1  load strobe for `ipoff`
- `ipoff`  in  PH_W  phase offset, in output-phase LSBs
- `isync`  in  1  phase restart command
- `ov`  out  1  phase valid
- `ophase`  out  PH_W  phase to sin/cos table
- `owrap`  out  1  accumulator overflowed on this sample, aligned with `ov`

## Operation
- **Registers:**
  - `acc[ACC_W]`, `fcw_act`, `fcw_shd`, `pend` (1 bit), `poff[PH_W]`, `lfsr[16]`.
  - Pipeline stage 1: `v1`, `ph1[ACC_W]`, `w1`.
  - Outputs are registered: `ov`, `ophase`, `owrap`.
- **FCW load:**
  - `ifcw_v=1` sets `fcw_shd<=ifcw` and `pend<=1`.
  - Repeated loads before use: last value wins.
- **FCW hand-over:**
  - Effective word `fcw_eff = (pend && (iv || isync)) ? fcw_shd : fcw_act`. `pend` here is the registered value, so a load in the same cycle is not yet visible.
  - In such a cycle, `fcw_act<=fcw_shd` and `pend<=0`, unless `ifcw_v` is also 1, in which case `pend` stays 1 with the new shadow.
  - Consequence: a new FCW first affects the increment at the first `iv`/`isync` cycle strictly after the load cycle.
- **Phase offset:** `ipoff_v=1` sets `poff<=ipoff`. Stage 1 uses the registered `poff`, so a new offset takes effect from the next cycle.
- **Stage 1, on `iv=1`:**
  - `base = isync ? 0 : acc`
  - `ph1 <= base + (poff << (ACC_W-PH_W))`, mod 2^ACC_W
  - `{w1, acc} <= base + fcw_eff`, where `w1` is the carry out
  - `v1 <= 1`
- **Stage 1, on `iv=0`:** `v1<=0`. If `isync=1`, `acc<=0` and the FCW hand-over above applies.
- **Stage 2, every cycle:**
  - `ov<=v1`, `owrap<=w1`.
  - If `v1=1`: `ophase <= (ph1 + d)[ACC_W-1 -: PH_W]`, mod 2^ACC_W, where `d = DITHER_EN ? (lfsr << (ACC_W-PH_W-16)) : 0`.
  - If `v1=0`: `ophase` holds.
- **LFSR:**
  - Fibonacci, taps x^16+x^14+x^13+x^11+1.
  - Advances once per cycle with `v1=1`.
  - `isync=1` reloads `LFSR_SEED`; sync overrides advance.
- **Sync scope:** `isync` does not flush samples already in stage 1/2.
- **Reset values:** all registers 0 except `lfsr=LFSR_SEED`. Outputs `ov=0`, `ophase=0`, `owrap=0`.
- **Reset mid-operation:** in-flight samples are discarded, and the pending FCW and offset are lost.

## Timing
- Latency: `iv` at cycle t gives `ov`/`ophase`/`owrap` at t+2. Throughput is 1 sample/cycle. No backpressure.
- First sample after reset or sync shows phase `poff` (accumulator contribution 0).
- `ov` is never asserted without a matching earlier `iv`. Gaps in `iv` freeze `acc`.
- Simultaneous events:
  - `ifcw_v`+`iv`: the increment uses the old word.
  - `isync`+`iv`: the sample emitted is from base 0, and `acc` ends at `fcw_eff`.
  - `isync`+`ifcw_v`: the new shadow is not applied until the next `iv`/`isync`.
- Wrap: `acc` wraps modulo 2^ACC_W with no saturation. `owrap` is high for exactly the sample whose increment carried.

## Test plan
All scenarios use `ACC_W=32`, `PH_W=12` and `DITHER_EN=0` unless stated.

1. Reset, load FCW 0x0100_0000, continuous `iv` -> `ophase` 0x000, 0x010, 0x020, … with first `ov` 2 cycles after first `iv`. `owrap=1` only on the 256th sample (0xFF0); the sequence repeats from 0x000.
2. FCW 0x0100_0000 running; load 0x0200_0000 in the same cycle as `iv` on sample 4 (0x040) -> samples 0x040, 0x050, 0x070, 0x090 (step changes one sample later).
3. Toggle `iv` 1-0-0-1-0-1 with FCW 0x0100_0000 -> exactly 3 `ov` pulses with phases 0x000, 0x010, 0x020. `ophase` holds between pulses.
4. Load `ipoff`=0x800 mid-stream, then assert `isync` together with `iv` -> the synced sample shows 0x800, the following samples show 0x810, 0x820. Samples already in flight are unaffected.
5. Assert `ireset` with 2 samples in flight -> `ov`/`ophase`/`owrap` are 0 immediately and no stale `ov` appears afterwards. After release, FCW is 0 and `ophase` is constant 0x000 on each `iv`.
6. `DITHER_EN=1`, FCW 0x0008_0000 -> each `ophase` equals the undithered value or that value +1. The sequence differs from the `DITHER_EN=0` sequence, and `isync` restarts an identical dithered sequence.
